// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: shared types and sizing helpers for the digit-serial modular
// multiplier.
//   state_t     : FSM encoding (IDLE, RUN)
//   iter_count  : compute cycles for an N-bit multiplier taken D bits per cycle
//   cnt_width   : width of the digit counter (at least one bit)
package mod_arith_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int iter_count(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // A single-iteration configuration would give clog2 = 0, so keep one bit.
  function automatic int cnt_width(input int n, input int d);
    int w;
    w = $clog2(iter_count(n, d));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mod_mul_ds_if.sv
// mod_mul_ds_if: request/response bundle of the modular multiplier.
//   start, a, b, p        : request from the caller
//   busy, done, err, result : status and product back to the caller
// Modports: master = caller side, slave = multiplier side.
interface mod_mul_ds_if #(
  parameter int N = 231
) ();

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] p;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] result;

  modport master (
    output start, a, b, p,
    input  busy, done, err, result
  );

  modport slave (
    input  start, a, b, p,
    output busy, done, err, result
  );

endinterface

// File: rtl/mod_dbl_add_step.sv
// mod_dbl_add_step: one MSB-first bit step of the interleaved modular
// multiplication, purely combinational.
//   i_r : running remainder, N+1 bits, guaranteed < p on entry
//   i_a : multiplicand (< p)
//   i_p : modulus
//   i_b : current multiplier bit
//   o_r : ((2*i_r mod p) + i_b*i_a) mod p, again < p
module mod_dbl_add_step #(
  parameter int N = 231
) (
  input  logic [N:0]   i_r,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_p,
  input  logic         i_b,
  output logic [N:0]   o_r
);

  logic [N:0] w_p;
  logic [N:0] w_dbl;
  logic [N:0] w_dbl_red;
  logic [N:0] w_sum;

  assign w_p = {1'b0, i_p};

  // i_r < p < 2^N, so doubling never overflows N+1 bits and one subtract is enough.
  assign w_dbl     = i_r + i_r;
  assign w_dbl_red = (w_dbl >= w_p) ? (w_dbl - w_p) : w_dbl;

  // Both addends are < p, so the sum is < 2p and one subtract restores R < p.
  assign w_sum = w_dbl_red + (i_b ? {1'b0, i_a} : {(N+1){1'b0}});
  assign o_r   = (w_sum >= w_p) ? (w_sum - w_p) : w_sum;

endmodule

// File: rtl/mod_mul_ds.sv
// mod_mul_ds: digit-serial modular multiplier, result = (A*B) mod p.
// Consumes D multiplier bits per cycle, MSB first, through a chain of D
// mod_dbl_add_step cells; ITER = ceil(N/D) compute cycles per product.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : mod_mul_ds_if slave (start/a/b/p in, busy/done/err/result out)
// Out-of-range requests (A >= p, B >= p or p < 2) finish the following cycle
// with err=1 and result=0 and never raise busy.
module mod_mul_ds
  import mod_arith_pkg::*;
#(
  parameter int N = 231,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         reset,
  mod_mul_ds_if.slave  bus
);

  localparam int ITER = iter_count(N, D);
  localparam int CW   = cnt_width(N, D);
  localparam int W    = ITER * D;  // B zero-padded to whole digits

  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  state_t       r_state;
  state_t       w_state_nxt;

  logic [N-1:0] r_a;
  logic [N-1:0] r_p;
  logic [W-1:0] r_bsh;   // latched B, shifted left by D each RUN cycle
  logic [N:0]   r_r;
  logic [CW-1:0] r_cnt;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic [N-1:0] r_result;

  logic         w_in_ok;
  logic         w_last;
  logic         w_accept_ok;
  logic         w_accept_bad;
  logic         w_step;
  logic         w_finish;
  logic [N:0]   w_chain [0:D];
  logic [N:0]   w_r_next;

  // p >= 2 is the same as p > 1.
  assign w_in_ok = (bus.a < bus.p) && (bus.b < bus.p) &&
                   (bus.p > {{(N-1){1'b0}}, 1'b1});
  assign w_last  = (r_cnt == CNT_LAST);

  // Step chain: cell j handles the j-th most significant bit of the current digit.
  assign w_chain[0] = r_r;
  for (genvar j = 0; j < D; j++) begin : g_step
    mod_dbl_add_step #(.N(N)) u_step (
      .i_r (w_chain[j]),
      .i_a (r_a),
      .i_p (r_p),
      .i_b (r_bsh[W-1-j]),
      .o_r (w_chain[j+1])
    );
  end
  assign w_r_next = w_chain[D];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a rejected request stays in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start && w_in_ok) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control decode for the datapath registers.
  always_comb begin
    w_accept_ok  = 1'b0;
    w_accept_bad = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept_ok  = w_in_ok;
          w_accept_bad = ~w_in_ok;
        end else begin
          w_accept_ok  = 1'b0;
          w_accept_bad = 1'b0;
        end
      end
      RUN: begin
        w_step   = 1'b1;
        w_finish = w_last;
      end
      default: begin
        w_step   = 1'b0;
        w_finish = 1'b0;
      end
    endcase
  end

  // Operand capture, remainder/counter update and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= {N{1'b0}};
      r_p      <= {N{1'b0}};
      r_bsh    <= {W{1'b0}};
      r_r      <= {(N+1){1'b0}};
      r_cnt    <= CNT_ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= {N{1'b0}};
    end else begin
      r_done <= 1'b0;
      if (w_accept_ok) begin
        r_a    <= bus.a;
        r_p    <= bus.p;
        r_bsh  <= W'(bus.b);
        r_r    <= {(N+1){1'b0}};
        r_cnt  <= CNT_ZERO;
        r_busy <= 1'b1;
        r_err  <= 1'b0;
      end else if (w_accept_bad) begin
        r_a      <= bus.a;
        r_p      <= bus.p;
        r_bsh    <= W'(bus.b);
        r_done   <= 1'b1;
        r_err    <= 1'b1;
        r_result <= {N{1'b0}};
      end else if (w_step) begin
        r_r   <= w_r_next;
        r_bsh <= r_bsh << D;
        if (w_finish) begin
          r_result <= w_r_next[N-1:0];
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_cnt    <= CNT_ZERO;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end else begin
        r_busy <= r_busy;
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.result = r_result;

endmodule

// File: doc/mod_mul_ds.md
# mod_mul_ds

Digit-serial modular multiplier computing result = (A·B) mod p for operands up to N bits, processing D multiplier bits per clock with interleaved doubling, addition and conditional subtraction (no `%` operator). It has a start/busy/done handshake, an input-range check, and back-to-back operation. It is the multiplier core the ECC point-add/point-double sequencers call. D trades area for latency.

## Interface
- N, 231, operand/modulus width in bits (N ≥ 2)
- D, 1, multiplier bits consumed per cycle (1 ≤ D ≤ N); ITER = ceil(N/D) compute cycles
- clk  input  1  clock
- reset  input  1  reset; synchronous, active-high
- start  input  1  request; sampled only while busy=0
- A  input  N  multiplicand; must satisfy A < p
- B  input  N  multiplier; must satisfy B < p
- p  input  N  modulus; must satisfy p ≥ 2
- busy  output  1  computation in progress; start ignored
- done  output  1  one-cycle pulse; result/err valid
- err  output  1  last accepted request had out-of-range inputs
- result  output  N  product mod p; held until the next done

## Operation
- States: IDLE, RUN. Reset puts the block in IDLE and clears busy, done, err, result and the digit counter.
- Accept: in IDLE with start=1, the block latches A, B and p into internal registers. Later input changes have no effect.
- Range check at accept: if A ≥ p, B ≥ p or p < 2:
  - stay in IDLE;
  - next cycle: done=1, err=1, result=0.
- Valid accept: R←0, counter←0, go to RUN, err←0.
- Algorithm (MSB-first). B is zero-extended at the top to ITER·D bits. For each bit b, from the MSB down:
  - R←2R; if R ≥ p then R←R−p;
  - if b=1 then R←R+A; if R ≥ p then R←R−p.
- Each RUN cycle applies D consecutive bit steps combinationally. The padded leading zero bits are harmless.
- Width rule: R is held in N+1 bits internally. Each intermediate value is < 2p < 2^(N+1). Invariant: R < p after every bit step.
- RUN ends when counter = ITER−1. On that edge:
  - result←R_next[N-1:0], done←1;
  - state→IDLE, counter→0.
- done is a single-cycle pulse. result and err hold their values until the next done.
- start while busy=1 is ignored, not queued.
- Reset during RUN aborts the operation: no done, and all outputs go to 0 on the next cycle.

## Timing
- Cycle 0: start=1 sampled at its closing edge (busy=0).
- Valid request: busy=1 in cycles 1..ITER; done=1, busy=0 and result valid in cycle ITER+1.
- Invalid request: done=1, err=1 in cycle 1; busy never asserts.
- Back-to-back: start=1 in the done cycle is accepted. Issue interval = ITER+1 cycles.
- Example latencies: N=231, D=1 → ITER=231; D=8 → ITER=29.
- The critical path is D chained step cells, each containing one N+1-bit add, two compares and two subtracts.

## Structure
- Package mod_arith_pkg holds:
  - state enum {IDLE, RUN};
  - function iter_count(N,D) = (N+D−1)/D;
  - counter width = clog2(iter_count).
- Sub-module mod_dbl_add_step: combinational, inputs R, A, p, bit b; output R'. It is instantiated D times in a chain (generate loop).
- The top level holds the FSM, operand registers, digit counter, and an MSB-first digit selection from the latched B.

## Test plan
- N=8, D=1, p=251, A=200, B=100, start in cycle 0 → busy cycles 1–8; done=1, err=0, result=171 in cycle 9.
- Same operands with D=4 → done in cycle 3, result=171. Same operands with D=3 (ITER=3, padding) → done in cycle 4, result=171.
- N=8, D=1, p=251, A=250, B=250 → result=1. A=0, B=137 → result=0. A=1, B=250 → result=250.
- A=251, B=5, p=251 → done=1, err=1, result=0 in cycle 1, no busy. Then a valid request (A=3, B=4) → err=0, result=12.
- Hold start=1 continuously, changing operands each done cycle → one result every 9 cycles (D=1). start pulses during busy are ignored.
- reset=1 in cycle 4 of a run → busy/done/result = 0 from cycle 5. No done appears. A new start afterwards completes normally.
